// File: rtl/division_pkg.sv
// Shared types for the division devices group: divider FSM states and the
// divisor value that means "stop".
package division_pkg;

    typedef enum logic {
        DIV_IDLE,
        DIV_RUN
    } div_state_e;

    localparam int unsigned DIV_STOP = 0;

endpackage

// File: rtl/prog_freq_divider_if.sv
// Control/status bundle of the programmable divider: count enable, divisor
// handshake and the divided outputs.
interface prog_freq_divider_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             div_valid;
    logic             div_ready;
    logic [WIDTH-1:0] div_value;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             out_div;
    logic             running;

    modport master (
        output en, div_valid, div_value,
        input  div_ready, count, tick, out_div, running
    );

    modport slave (
        input  en, div_valid, div_value,
        output div_ready, count, tick, out_div, running
    );
endinterface

// File: rtl/div_period_counter.sv
// Modulo counter: advances on en, returns to 0 after reaching term, and
// flags that terminal cycle on wrap.
module div_period_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && !clr && (count == term);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_freq_divider.sv
// Programmable divide-by-N: divisor handshake with a one-deep pending slot,
// IDLE/RUN control, registered terminal tick and near-50% divided waveform.
module prog_freq_divider
    import division_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prog_freq_divider_if.slave   bus
);

    div_state_e       state, state_next;
    logic [WIDTH-1:0] cur_div, cur_div_next;
    logic             pending_valid, pending_valid_next;
    logic [WIDTH-1:0] pending_div, pending_div_next;
    logic             tick, tick_next;
    logic             out_div, out_div_next;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic             wrap;
    logic             run_en;
    logic             accept;

    // High phase covers counts below ceil(d/2); one extra bit keeps d+1 from overflowing.
    function automatic logic high_phase(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        logic [WIDTH:0] half;
        half = ({1'b0, d} + (WIDTH+1)'(1)) >> 1;
        return {1'b0, c} < half;
    endfunction

    assign run_en = bus.en && (state == DIV_RUN);
    assign accept = bus.div_valid && !pending_valid;

    div_period_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en),
        .clr   (state == DIV_IDLE),
        .term  (cur_div - WIDTH'(1)),
        .count (count),
        .wrap  (wrap)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next         = state;
        cur_div_next       = cur_div;
        pending_valid_next = pending_valid;
        pending_div_next   = pending_div;
        tick_next          = 1'b0;
        out_div_next       = out_div;
        count_next         = wrap ? '0 : count + WIDTH'(1);

        if (accept) begin
            pending_valid_next = 1'b1;
            pending_div_next   = bus.div_value;
        end

        case (state)
            DIV_IDLE: begin
                out_div_next = 1'b0;
                if (pending_valid) begin
                    pending_valid_next = 1'b0;
                    if (pending_div != WIDTH'(DIV_STOP)) begin
                        state_next   = DIV_RUN;
                        cur_div_next = pending_div;
                        tick_next    = 1'b1;
                        out_div_next = high_phase('0, pending_div);
                    end
                end
            end
            DIV_RUN: begin
                if (bus.en) begin
                    tick_next = wrap;
                    // Divisor changes only at the wrap, so the waveform never glitches.
                    if (wrap && pending_valid) begin
                        pending_valid_next = 1'b0;
                        cur_div_next       = pending_div;
                    end
                    if (wrap && pending_valid && pending_div == WIDTH'(DIV_STOP)) begin
                        state_next   = DIV_IDLE;
                        tick_next    = 1'b0;
                        out_div_next = 1'b0;
                    end else begin
                        out_div_next = high_phase(count_next, cur_div_next);
                    end
                end
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= DIV_IDLE;
            cur_div       <= '0;
            pending_valid <= 1'b0;
            pending_div   <= '0;
            tick          <= 1'b0;
            out_div       <= 1'b0;
        end else begin
            state         <= state_next;
            cur_div       <= cur_div_next;
            pending_valid <= pending_valid_next;
            pending_div   <= pending_div_next;
            tick          <= tick_next;
            out_div       <= out_div_next;
        end
    end

    assign bus.div_ready = !pending_valid;
    assign bus.count     = count;
    assign bus.tick      = tick;
    assign bus.out_div   = out_div;
    assign bus.running   = (state == DIV_RUN);

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench for prog_freq_divider: each stimulus cycle pushes the outputs
// expected during that cycle; a monitor pops and compares mid-cycle.
module tb_prog_freq_divider;

    logic clk;
    logic rst_n;

    prog_freq_divider_if #(.WIDTH(8)) bus ();

    prog_freq_divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] count;
        logic       tick;
        logic       out_div;
        logic       running;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc_idx  = 0;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input logic [31:0] actual,
                         input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, actual, required);
        end
    endtask

    // One clock cycle: inputs applied just after the edge, expected outputs for
    // the remainder of that cycle queued for the monitor.
    task automatic cyc(input logic rst, input logic en, input logic v, input logic [7:0] val,
                       input logic [7:0] ec, input logic et, input logic eo,
                       input logic er, input logic erdy);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = rst;
        bus.en        = en;
        bus.div_valid = v;
        bus.div_value = val;
        e.cyc     = cyc_idx;
        e.count   = ec;
        e.tick    = et;
        e.out_div = eo;
        e.running = er;
        e.ready   = erdy;
        exp_q.push_back(e);
        cyc_idx++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("count",     mon_e.cyc, 32'(bus.count),     32'(mon_e.count));
                check("tick",      mon_e.cyc, 32'(bus.tick),      32'(mon_e.tick));
                check("out_div",   mon_e.cyc, 32'(bus.out_div),   32'(mon_e.out_div));
                check("running",   mon_e.cyc, 32'(bus.running),   32'(mon_e.running));
                check("div_ready", mon_e.cyc, 32'(bus.div_ready), 32'(mon_e.ready));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc_idx);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] c;
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.div_valid = 1'b0;
        bus.div_value = '0;

        //  rst en v  val   cnt t o r rdy
        cyc(0, 0, 0, 0,     0, 0,0,0,1);   // in reset
        cyc(1, 1, 0, 0,     0, 0,0,0,1);
        cyc(1, 1, 1, 4,     0, 0,0,0,1);   // offer N=4 in IDLE
        cyc(1, 1, 0, 0,     0, 0,0,0,0);   // pending, ready low one cycle
        cyc(1, 1, 0, 0,     0, 1,1,1,1);   // first tick
        cyc(1, 1, 0, 0,     1, 0,1,1,1);
        cyc(1, 1, 0, 0,     2, 0,0,1,1);
        cyc(1, 1, 0, 0,     3, 0,0,1,1);
        cyc(1, 1, 0, 0,     0, 1,1,1,1);
        cyc(1, 1, 1, 5,     1, 0,1,1,1);   // N=5 offered mid-period
        cyc(1, 1, 1, 9,     2, 0,0,1,0);   // second offer held off
        cyc(1, 1, 0, 0,     3, 0,0,1,0);   // boundary applies 5
        cyc(1, 1, 0, 0,     0, 1,1,1,1);
        cyc(1, 1, 0, 0,     1, 0,1,1,1);
        cyc(1, 1, 0, 0,     2, 0,1,1,1);
        cyc(1, 1, 0, 0,     3, 0,0,1,1);
        cyc(1, 1, 1, 3,     4, 0,0,1,1);   // offer N=3 in boundary cycle
        cyc(1, 1, 1, 2,     0, 1,1,1,0);   // old N=5 runs again; offer of 2 held off
        cyc(1, 1, 0, 0,     1, 0,1,1,0);
        cyc(1, 1, 0, 0,     2, 0,1,1,0);
        cyc(1, 1, 0, 0,     3, 0,0,1,0);
        cyc(1, 1, 0, 0,     4, 0,0,1,0);   // boundary applies 3
        cyc(1, 1, 0, 0,     0, 1,1,1,1);
        cyc(1, 0, 0, 0,     1, 0,1,1,1);   // enable gap
        cyc(1, 0, 0, 0,     1, 0,1,1,1);
        cyc(1, 1, 0, 0,     1, 0,1,1,1);
        cyc(1, 1, 0, 0,     2, 0,0,1,1);
        cyc(1, 1, 1, 1,     0, 1,1,1,1);   // offer N=1
        cyc(1, 1, 0, 0,     1, 0,1,1,0);
        cyc(1, 1, 0, 0,     2, 0,0,1,0);
        cyc(1, 1, 0, 0,     0, 1,1,1,1);   // N=1 active
        cyc(1, 0, 0, 0,     0, 1,1,1,1);
        cyc(1, 1, 1, 0,     0, 0,1,1,1);   // offer stop in boundary cycle
        cyc(1, 1, 0, 0,     0, 1,1,1,0);   // N=1 one more period
        cyc(1, 0, 1, 7,     0, 0,0,0,1);   // back in IDLE; offer N=7 with en low
        cyc(1, 0, 0, 0,     0, 0,0,0,0);
        cyc(1, 1, 0, 0,     0, 1,1,1,1);   // started regardless of en
        cyc(1, 1, 0, 0,     1, 0,1,1,1);
        cyc(1, 1, 0, 0,     2, 0,1,1,1);
        cyc(1, 1, 0, 0,     3, 0,1,1,1);
        cyc(1, 1, 1, 2,     4, 0,0,1,1);   // N=2 pending
        cyc(1, 0, 0, 0,     5, 0,0,1,0);   // held at count 5
        cyc(0, 0, 0, 0,     0, 0,0,0,1);   // async reset, no edge in between
        cyc(1, 1, 0, 0,     0, 0,0,0,1);
        cyc(1, 1, 0, 0,     0, 0,0,0,1);   // pending was discarded
        cyc(1, 1, 1, 255,   0, 0,0,0,1);   // maximum divisor
        cyc(1, 1, 0, 0,     0, 0,0,0,0);
        cyc(1, 1, 0, 0,     0, 1,1,1,1);
        for (int k = 1; k <= 256; k++) begin
            c = 8'(k % 255);
            cyc(1, 1, 0, 0, c, (c == 8'd0), (c < 8'd128), 1'b1, 1'b1);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain cyc=%0d actual=%0d required=0", cyc_idx, exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
